// File: rtl/ofm_maxpool_rx.sv
// ofm_maxpool_rx: collects a gapless 25-word 5x5 OFM burst, then streams the
// 16 results of a 2x2 stride-1 unsigned max-pool over it.
module ofm_maxpool_rx #(
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err
);

  localparam int N_WORDS = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    POOL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]        p_q, p_d;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic              pool_go;
  logic              err_d;

  // Row-major 5x5 frame store; word k lives at index k.
  logic [DATA_W-1:0] frame_q [N_WORDS];

  // Pool window taps: top-left index is r*5+c with r=p/4, c=p%4.
  logic [4:0]        rd_base;
  logic [DATA_W-1:0] tap_tl, tap_tr, tap_bl, tap_br;

  // Two-stage pool pipeline: row-pair maxima, then final max.
  logic [DATA_W-1:0] top_q, bot_q;
  logic              s1_vld_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              err_q;

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Next-state logic: frame capture, gap detection and pool sequencing.
  always_comb begin
    state_d  = state_q;
    rx_cnt_d = rx_cnt_q;
    p_d      = p_q;
    wr_en    = 1'b0;
    wr_addr  = rx_cnt_q;
    pool_go  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_addr  = 5'd0;
          rx_cnt_d = 5'd1;
          state_d  = RECV;
        end
      end
      RECV: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (rx_cnt_q == 5'(N_WORDS - 1)) begin
            rx_cnt_d = 5'd0;
            p_d      = 4'd0;
            state_d  = POOL;
          end else begin
            rx_cnt_d = rx_cnt_q + 5'd1;
          end
        end else begin
          // A hole in the burst invalidates the whole frame.
          err_d    = 1'b1;
          rx_cnt_d = 5'd0;
          state_d  = IDLE;
        end
      end
      POOL: begin
        // Input is ignored here; trailing words never start a frame.
        pool_go = 1'b1;
        p_d     = p_q + 4'd1;
        if (p_q == 4'd15) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        rx_cnt_d = 5'd0;
        p_d      = 4'd0;
      end
    endcase
  end

  // Window address and the four taps for the current pool index.
  always_comb begin
    rd_base = ({3'd0, p_q[3:2]} * 5'd5) + {3'd0, p_q[1:0]};
    tap_tl  = frame_q[rd_base];
    tap_tr  = frame_q[rd_base + 5'd1];
    tap_bl  = frame_q[rd_base + 5'd5];
    tap_br  = frame_q[rd_base + 5'd6];
  end

  // Control registers; busy follows the next state so it drops on return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rx_cnt_q <= 5'd0;
      p_q      <= 4'd0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_cnt_q <= rx_cnt_d;
      p_q      <= p_d;
      busy_q   <= (state_d != IDLE);
      err_q    <= err_d;
    end
  end

  // Frame store write port; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_q[wr_addr] <= in_data;
    end
  end

  // Pool pipeline: stage 1 reduces each row pair, stage 2 drives the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      top_q       <= '0;
      bot_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_vld_q    <= pool_go;
      top_q       <= umax(tap_tl, tap_tr);
      bot_q       <= umax(tap_bl, tap_br);
      out_valid_q <= s1_vld_q;
      out_data_q  <= s1_vld_q ? umax(top_q, bot_q) : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ofm_maxpool_rx.sv
// tb_ofm_maxpool_rx: drives OFM bursts and checks pooled output data, timing,
// err pulses and busy against a frame-level reference model.
module tb_ofm_maxpool_rx;

  localparam int DATA_W = 36;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              err;

  ofm_maxpool_rx #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected pooled word and the edge after which it must be visible.
  typedef struct {
    logic [DATA_W-1:0] d;
    int                c;
  } exp_t;
  exp_t exp_q[$];

  logic [DATA_W-1:0] fr_w [25];
  int  err_cyc = -1;
  bit  mon_en  = 1'b0;

  function automatic logic [DATA_W-1:0] max4(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Reference: pooled word p of the frame whose last word was sampled at edge t.
  task automatic model_frame(input int t);
    exp_t e;
    for (int p = 0; p < 16; p++) begin
      int r, c;
      r   = p / 4;
      c   = p % 4;
      e.d = max4(fr_w[r*5+c], fr_w[r*5+c+1], fr_w[(r+1)*5+c], fr_w[(r+1)*5+c+1]);
      e.c = t + 2 + p;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends fr_w as a gapless burst and records the expected pooled stream.
  task automatic send_frame();
    for (int i = 0; i < 25; i++) begin
      in_valid = 1'b1;
      in_data  = fr_w[i];
      @(posedge clk);
      #1;
      if (i == 0) chk_eq("busy_after_first", busy, 1'b1);
    end
    model_frame(cyc);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic fill_ramp(input bit down);
    for (int i = 0; i < 25; i++) fr_w[i] = down ? DATA_W'(24 - i) : DATA_W'(i);
  endtask

  task automatic fill_rand(input bit narrow);
    for (int i = 0; i < 25; i++) begin
      if (narrow) fr_w[i] = DATA_W'($urandom_range(0, 7));
      else        fr_w[i] = {$urandom(), $urandom()} & {DATA_W{1'b1}};
    end
  endtask

  // Monitor: every cycle, out_valid/out_data/err must match the model exactly.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_v;
      exp_v = (exp_q.size() > 0) && (exp_q[0].c == cyc);
      chk_eq("out_valid", out_valid, exp_v);
      if (out_valid && exp_v) begin
        chk_eq("pool_data", out_data, exp_q[0].d);
        $display("pool word cyc=%0d data=%h exp=%h", cyc, out_data, exp_q[0].d);
        void'(exp_q.pop_front());
      end else if (!out_valid) begin
        chk_eq("quiet_data", out_data, '0);
        if (exp_q.size() > 0 && exp_q[0].c <= cyc) void'(exp_q.pop_front());
      end
      chk_eq("err", err, cyc == err_cyc);
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_eq("rst_out_valid", out_valid, 1'b0);
    chk_eq("rst_out_data", out_data, '0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_err", err, 1'b0);
    mon_en = 1'b1;

    // 1: ascending ramp
    fill_ramp(1'b0);
    send_frame();
    idle(20);
    chk_eq("busy_idle_1", busy, 1'b0);

    // 2: descending ramp
    fill_ramp(1'b1);
    send_frame();
    idle(20);

    // 3: full-width values with a single zero in the middle
    for (int i = 0; i < 25; i++) fr_w[i] = {DATA_W{1'b1}};
    fr_w[12] = '0;
    send_frame();
    idle(20);

    // 4: gap after 10 words, then a clean ramp
    fill_ramp(1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = fr_w[i];
      @(posedge clk);
      #1;
    end
    err_cyc = cyc + 1;
    idle(1);
    chk_eq("gap_busy", busy, 1'b0);
    idle(3);
    send_frame();
    idle(20);

    // 5: back-to-back ramps, second starts while pooled word 15 is shown
    fill_ramp(1'b0);
    send_frame();
    idle(17);
    chk_eq("b2b_idle_busy", busy, 1'b0);
    send_frame();
    idle(20);

    // 6: reset in POOL at p=5
    fill_rand(1'b0);
    send_frame();
    idle(5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].c >= cyc) void'(exp_q.pop_back());
    chk_eq("abort_out_valid", out_valid, 1'b0);
    chk_eq("abort_out_data", out_data, '0);
    chk_eq("abort_busy", busy, 1'b0);
    idle(2);
    fill_ramp(1'b1);
    send_frame();
    idle(20);

    // Random frames; some keep in_valid high through POOL, which must be ignored.
    for (int f = 0; f < 6; f++) begin
      fill_rand(f[0]);
      send_frame();
      if (f[1]) begin
        for (int k = 0; k < 16; k++) begin
          in_valid = 1'b1;
          in_data  = {$urandom(), $urandom()} & {DATA_W{1'b1}};
          @(posedge clk);
          #1;
        end
        idle(1 + $urandom_range(0, 3));
      end else begin
        idle(17 + $urandom_range(0, 4));
      end
    end

    idle(25);
    chk_eq("drain_empty", exp_q.size(), 0);
    chk_eq("final_busy", busy, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ofm_maxpool_rx.md
Name: ofm_maxpool_rx

Overview:
- Receiver for the 5x5 OFM stream produced by the pipelined convolution engine.
- Accepts 25 consecutive 36-bit OFM words, qualified by the engine's out_valid, into a 5x5 buffer.
- Runs a 2x2, stride-1 max-pool on the buffer and streams 16 pooled words downstream.
- Sits between the convolution engine and the next layer or testbench checker.

Parameters:
- DATA_W, 36, OFM word width. Must match the convolution output width.
- Map dimensions are fixed: 5x5 in, 4x4 out.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  OFM word valid. Connects to the engine's out_valid.
- in_data  input  DATA_W  OFM word. Connects to Out_OFM. Raster order, row-major.
- out_valid  output  1  pooled word valid. Registered.
- out_data  output  DATA_W  pooled word. Registered. Zero when out_valid=0.
- busy  output  1  high in RECV or POOL. Registered.
- err  output  1  one-cycle pulse on a short burst. Registered.

Behaviour:
- Reset:
  - Clock and reset behaviour is one clock; reset is synchronous and active-high.
  - On reset: out_valid=0, out_data=0, busy=0, err=0, state=IDLE, all counters=0.
  - Buffer contents after reset are don't-care.
  - Reset asserted in any state aborts the frame. There is no err pulse, and output is quiet from the next cycle.
- States: IDLE, RECV, POOL.
- IDLE:
  - If in_valid=1, store in_data as word 0 (buf[0][0]), set rx_cnt=1, go to RECV.
  - Otherwise stay in IDLE.
- RECV:
  - Each cycle with in_valid=1: store in_data at buf[rx_cnt/5][rx_cnt%5] and increment rx_cnt.
  - When word 24 is stored (rx_cnt==24 and in_valid=1): go to POOL, set p=0.
  - If in_valid=0 while rx_cnt<25 (a gap mid-burst): pulse err for 1 cycle, discard the frame, go to IDLE.
  - Bursts must be gapless.
- POOL:
  - For p=0..15: r=p/4, c=p%4.
  - out_data <= unsigned max of buf[r][c], buf[r][c+1], buf[r+1][c], buf[r+1][c+1].
  - out_valid <= 1 on each of these loads.
  - Increment p each cycle. After p=15, go to IDLE.
  - in_valid during POOL is ignored: no store, no err.
- Timing:
  - If word 24 is sampled at edge T, pooled word 0 is visible after edge T+2.
  - The 16 outputs are on consecutive cycles; out_valid never gaps within a frame.
- Back-to-back frames:
  - The state is IDLE during the cycle in which pooled word 15 is presented.
  - in_valid in that cycle starts a new frame. The dead time between frames is therefore 0.
- Arithmetic:
  - Comparisons are unsigned and full DATA_W width, with no truncation.
  - On equal values the result is that value; tie order is irrelevant.
- busy:
  - Registered from the next-state logic, so it is high exactly while the state is RECV or POOL.
  - It is low in the cycle the frame returns to IDLE.
- Extra words:
  - The 26th consecutive in_valid cycle lands in POOL and is ignored.
  - The bench must not expect it to start a new frame.

Test Plan:
1. Reset, then 25 words with in_data=k (k=0..24).
   - Required: 16 outputs starting at T+2: 6,7,8,9, 11,12,13,14, 16,17,18,19, 21,22,23,24. No err.
2. Descending frame, in_data=24-k.
   - Required: outputs 24,23,22,21, 19,18,17,16, 14,13,12,11, 9,8,7,6.
3. Frame of all 36'hF_FFFF_FFFF except word 12=0.
   - Required: all 16 outputs = 36'hF_FFFF_FFFF, confirming full-width unsigned compare.
4. Drop in_valid after 10 words.
   - Required: err=1 for exactly 1 cycle, busy=0 next cycle, no out_valid.
   - Then send a full ramp frame and check it pools correctly, as in scenario 1.
5. Two ramp frames, frame 2 starting in the cycle pooled word 15 of frame 1 is shown.
   - Required: 32 correct outputs, with out_valid low only for the pipeline gap between the frames' pool phases.
6. Assert rst during POOL at p=5.
   - Required: out_valid=0, busy=0, out_data=0 the next cycle.
   - A subsequent frame pools correctly.
